// File: rtl/sram_mem_ctrl.sv
// Fixed-timing single-word controller for an external asynchronous SRAM.
// Turns a go/complete handshake into SETUP/ACCESS/HOLD strobe sequencing.
module sram_mem_ctrl #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              w_rn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              isWrite_q, isWrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dqOut_q, dqOut_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ceN_q, ceN_d;
    logic              weN_q, weN_d;
    logic              oeN_q, oeN_d;
    logic              dqOe_q, dqOe_d;
    logic              memValid_q, memValid_d;
    logic              busy_q, busy_d;
    logic              inCycle;

    // Next-state logic; request fields are captured only when leaving IDLE,
    // so a go seen while busy has no effect at all.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        dqOut_d   = dqOut_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d   = SETUP;
                    isWrite_d = w_rn;
                    addr_d    = address;
                    if (w_rn) begin
                        dqOut_d = wdata;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                count_d = CNT_LOAD;
            end
            ACCESS: begin
                if (count_q == '0) begin
                    state_d = HOLD;
                    if (!isWrite_q) begin
                        rdata_d = sram_dq_in;
                    end
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the upcoming state and then registered, so
    // every SRAM pin changes only at a clock edge and never glitches.
    always_comb begin
        inCycle    = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
        ceN_d      = !inCycle;
        weN_d      = !((state_d == ACCESS) && isWrite_d);
        oeN_d      = !((state_d == ACCESS) && !isWrite_d);
        dqOe_d     = inCycle && isWrite_d;
        memValid_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            isWrite_q  <= 1'b0;
            addr_q     <= '0;
            dqOut_q    <= '0;
            rdata_q    <= '0;
            ceN_q      <= 1'b1;
            weN_q      <= 1'b1;
            oeN_q      <= 1'b1;
            dqOe_q     <= 1'b0;
            memValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            isWrite_q  <= isWrite_d;
            addr_q     <= addr_d;
            dqOut_q    <= dqOut_d;
            rdata_q    <= rdata_d;
            ceN_q      <= ceN_d;
            weN_q      <= weN_d;
            oeN_q      <= oeN_d;
            dqOe_q     <= dqOe_d;
            memValid_q <= memValid_d;
            busy_q     <= busy_d;
        end
    end

    assign rdata       = rdata_q;
    assign mem_valid   = memValid_q;
    assign busy        = busy_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dqOut_q;
    assign sram_dq_oe  = dqOe_q;
    assign sram_ce_n   = ceN_q;
    assign sram_we_n   = weN_q;
    assign sram_oe_n   = oeN_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: one instance at WAIT_CYCLES=2, one at
// WAIT_CYCLES=1, sharing request inputs, each with its own SRAM model.
module tb_sram_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go, wRn;
    logic [12:0] address;
    logic [7:0]  wdata;

    logic [7:0]  rdataA, dqOutA, dqInA, rdataB, dqOutB, dqInB;
    logic [12:0] sramAddrA, sramAddrB;
    logic        memValidA, busyA, dqOeA, ceNA, weNA, oeNA;
    logic        memValidB, busyB, dqOeB, ceNB, weNB, oeNB;

    sram_mem_ctrl #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .rst(rst), .go(go), .w_rn(wRn), .address(address), .wdata(wdata),
        .rdata(rdataA), .mem_valid(memValidA), .busy(busyA), .sram_addr(sramAddrA),
        .sram_dq_out(dqOutA), .sram_dq_oe(dqOeA), .sram_dq_in(dqInA),
        .sram_ce_n(ceNA), .sram_we_n(weNA), .sram_oe_n(oeNA)
    );

    sram_mem_ctrl #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(1)) dutB (
        .clk(clk), .rst(rst), .go(go), .w_rn(wRn), .address(address), .wdata(wdata),
        .rdata(rdataB), .mem_valid(memValidB), .busy(busyB), .sram_addr(sramAddrB),
        .sram_dq_out(dqOutB), .sram_dq_oe(dqOeB), .sram_dq_in(dqInB),
        .sram_ce_n(ceNB), .sram_we_n(weNB), .sram_oe_n(oeNB)
    );

    // Behavioural asynchronous SRAMs, one per instance
    bit [7:0] memA [0:8191];
    bit [7:0] memB [0:8191];
    always @(posedge clk) begin
        if (!ceNA && !weNA && dqOeA) memA[sramAddrA] <= dqOutA;
        if (!ceNB && !weNB && dqOeB) memB[sramAddrB] <= dqOutB;
    end
    assign dqInA = (!ceNA && !oeNA) ? memA[sramAddrA] : 8'h00;
    assign dqInB = (!ceNB && !oeNB) ? memB[sramAddrB] : 8'h00;

    logic        sel;
    logic [7:0]  obsRdata, obsDqOut;
    logic [12:0] obsAddr;
    logic        obsValid, obsBusy, obsDqOe, obsCeN, obsWeN, obsOeN;
    assign obsRdata = sel ? rdataB    : rdataA;
    assign obsDqOut = sel ? dqOutB    : dqOutA;
    assign obsAddr  = sel ? sramAddrB : sramAddrA;
    assign obsValid = sel ? memValidB : memValidA;
    assign obsBusy  = sel ? busyB     : busyA;
    assign obsDqOe  = sel ? dqOeB     : dqOeA;
    assign obsCeN   = sel ? ceNB      : ceNA;
    assign obsWeN   = sel ? weNB      : weNA;
    assign obsOeN   = sel ? oeNB      : oeNA;

    int testsRun = 0;
    int testsFailed = 0;

    int addrCeCnt, ceLowCnt, weLowCnt, oeLowCnt, dqOeCnt, dqOeDataOk, bothLow;
    int busyCnt, addr2Cnt, validCnt, validIdx, validIdx2, lastDqOeIdx, firstOeLowIdx;
    logic [7:0] rdataAtValid, rdataAtValid2;

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Issues a request at negedge 0 and tallies the selected instance's
    // outputs over the following nCycles negedges (cycle index = negedge index).
    task automatic collectTxn(input logic wr1, input logic [12:0] a1, input logic [7:0] d1,
                              input logic wr2, input logic [12:0] a2, input logic [7:0] d2,
                              input logic [15:0] goMask, input int nCycles);
        addrCeCnt = 0; ceLowCnt = 0; weLowCnt = 0; oeLowCnt = 0; dqOeCnt = 0;
        dqOeDataOk = 0; bothLow = 0; busyCnt = 0; addr2Cnt = 0; validCnt = 0;
        validIdx = -1; validIdx2 = -1; lastDqOeIdx = -1; firstOeLowIdx = -1;
        rdataAtValid = 8'h00; rdataAtValid2 = 8'h00;
        @(negedge clk);
        wRn = wr1; address = a1; wdata = d1; go = goMask[0];
        for (int i = 1; i <= nCycles; i++) begin
            @(negedge clk);
            if (!obsCeN && obsAddr == a1) addrCeCnt++;
            if (!obsCeN) ceLowCnt++;
            if (!obsWeN) weLowCnt++;
            if (!obsOeN) begin
                oeLowCnt++;
                if (firstOeLowIdx < 0) firstOeLowIdx = i;
            end
            if (obsDqOe) begin
                dqOeCnt++;
                lastDqOeIdx = i;
                if (obsDqOut == d1) dqOeDataOk++;
            end
            if (!obsWeN && !obsOeN) bothLow++;
            if (obsBusy) busyCnt++;
            if (obsAddr == a2 && a2 != a1) addr2Cnt++;
            if (obsValid) begin
                validCnt++;
                if (validIdx < 0) begin
                    validIdx = i; rdataAtValid = obsRdata;
                end else if (validIdx2 < 0) begin
                    validIdx2 = i; rdataAtValid2 = obsRdata;
                end
            end
            if (i == 1) begin
                wRn = wr2; address = a2; wdata = d2;
            end
            go = goMask[i];
        end
        go = 1'b0;
    endtask

    task automatic test_reset;
        int seenValid;
        rst = 1'b1; go = 1'b0; wRn = 1'b0; address = '0; wdata = '0; sel = 1'b0;
        #2 rst = 1'b0;
        idleCycles(2);
        testsRun++;
        if ({memValidA, busyA, dqOeA, ceNA, weNA, oeNA} !== 6'b000111) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000111", {memValidA, busyA, dqOeA, ceNA, weNA, oeNA});
        end
        testsRun++;
        if ({rdataA, dqOutA, sramAddrA} !== 29'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: rdata %h dq_out %h addr %h expected all zero", rdataA, dqOutA, sramAddrA);
        end
        rst = 1'b1;
        seenValid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (memValidA) seenValid++;
        end
        testsRun++;
        if (busyA !== 1'b0 || seenValid != 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: busy %b valid pulses %0d expected 0 0", busyA, seenValid);
        end
    endtask

    task automatic test_write(input logic useB, input logic [12:0] a, input logic [7:0] d, input int w);
        sel = useB;
        collectTxn(1'b1, a, d, 1'b1, a, d, 16'h0001, 10);
        testsRun++;
        if (addrCeCnt != w + 2 || ceLowCnt != w + 2) begin
            testsFailed++;
            $display("[TB] FAIL wr_addr_ce W%0d: addr cycles %0d ce cycles %0d expected %0d", w, addrCeCnt, ceLowCnt, w + 2);
        end
        testsRun++;
        if (weLowCnt != w) begin
            testsFailed++;
            $display("[TB] FAIL wr_we_low W%0d: got %0d expected %0d", w, weLowCnt, w);
        end
        testsRun++;
        if (dqOeCnt != w + 2 || dqOeDataOk != w + 2) begin
            testsFailed++;
            $display("[TB] FAIL wr_dq W%0d: oe cycles %0d data ok %0d expected %0d", w, dqOeCnt, dqOeDataOk, w + 2);
        end
        testsRun++;
        if (oeLowCnt != 0 || bothLow != 0) begin
            testsFailed++;
            $display("[TB] FAIL wr_oe_n W%0d: oe low %0d both low %0d expected 0 0", w, oeLowCnt, bothLow);
        end
        testsRun++;
        if (validCnt != 1 || validIdx != w + 3) begin
            testsFailed++;
            $display("[TB] FAIL wr_valid W%0d: pulses %0d at %0d expected 1 at %0d", w, validCnt, validIdx, w + 3);
        end
    endtask

    task automatic test_read(input logic useB, input logic [12:0] a, input logic [7:0] expD, input int w);
        sel = useB;
        collectTxn(1'b0, a, 8'h00, 1'b0, a, 8'h00, 16'h0001, 10);
        testsRun++;
        if (oeLowCnt != w || dqOeCnt != 0 || weLowCnt != 0) begin
            testsFailed++;
            $display("[TB] FAIL rd_strobes W%0d: oe low %0d dq_oe %0d we low %0d expected %0d 0 0", w, oeLowCnt, dqOeCnt, weLowCnt, w);
        end
        testsRun++;
        if (validCnt != 1 || validIdx != w + 3) begin
            testsFailed++;
            $display("[TB] FAIL rd_valid W%0d: pulses %0d at %0d expected 1 at %0d", w, validCnt, validIdx, w + 3);
        end
        testsRun++;
        if (rdataAtValid !== expD) begin
            testsFailed++;
            $display("[TB] FAIL rd_data W%0d: got %h expected %h", w, rdataAtValid, expD);
        end
    endtask

    task automatic test_write_keeps_rdata;
        sel = 1'b0;
        collectTxn(1'b1, 13'h0007, 8'h3C, 1'b1, 13'h0007, 8'h3C, 16'h0001, 10);
        testsRun++;
        if (rdataA !== 8'hA5) begin
            testsFailed++;
            $display("[TB] FAIL wr_keeps_rdata: got %h expected a5", rdataA);
        end
    endtask

    task automatic test_go_ignored;
        sel = 1'b0;
        collectTxn(1'b1, 13'h0009, 8'h11, 1'b0, 13'h0077, 8'h00, 16'h0015, 12);
        testsRun++;
        if (validCnt != 1 || validIdx != 5) begin
            testsFailed++;
            $display("[TB] FAIL busy_go_valid: pulses %0d at %0d expected 1 at 5", validCnt, validIdx);
        end
        testsRun++;
        if (busyCnt != 5 || addr2Cnt != 0) begin
            testsFailed++;
            $display("[TB] FAIL busy_go_side: busy cycles %0d stray addr %0d expected 5 0", busyCnt, addr2Cnt);
        end
    endtask

    task automatic test_back_to_back;
        sel = 1'b0;
        collectTxn(1'b1, 13'h1FFF, 8'h5C, 1'b0, 13'h0000, 8'h00, 16'h0FFF, 12);
        testsRun++;
        if (validCnt != 2 || validIdx != 5 || validIdx2 != 11) begin
            testsFailed++;
            $display("[TB] FAIL b2b_valid: pulses %0d at %0d and %0d expected 2 at 5 and 11", validCnt, validIdx, validIdx2);
        end
        testsRun++;
        if (firstOeLowIdx - lastDqOeIdx - 1 < 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_turnaround: undriven gap %0d expected at least 2", firstOeLowIdx - lastDqOeIdx - 1);
        end
        testsRun++;
        if (addrCeCnt != 4 || weLowCnt != 2 || oeLowCnt != 2 || bothLow != 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_strobes: addr %0d we %0d oe %0d both %0d expected 4 2 2 0", addrCeCnt, weLowCnt, oeLowCnt, bothLow);
        end
        idleCycles(20);
    endtask

    task automatic test_reset_mid;
        int seenValid;
        sel = 1'b0;
        seenValid = 0;
        @(negedge clk);
        wRn = 1'b1; address = 13'h0012; wdata = 8'h5A; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (weNA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_pre_we: got %b expected 0", weNA);
        end
        rst = 1'b0;
        #1;
        testsRun++;
        if ({ceNA, weNA, oeNA, dqOeA, busyA, memValidA} !== 6'b111000) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_ctrl: got %b expected 111000", {ceNA, weNA, oeNA, dqOeA, busyA, memValidA});
        end
        testsRun++;
        if (rdataA !== 8'h00 || sramAddrA !== 13'h0000 || dqOutA !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_data: rdata %h addr %h dq_out %h expected 0 0 0", rdataA, sramAddrA, dqOutA);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (memValidA) seenValid++;
        end
        testsRun++;
        if (seenValid != 0 || busyA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_no_valid: pulses %0d busy %b expected 0 0", seenValid, busyA);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write(1'b0, 13'h0005, 8'hA5, 2);
        test_read(1'b0, 13'h0005, 8'hA5, 2);
        test_write_keeps_rdata();
        test_go_ignored();
        test_back_to_back();
        test_reset_mid();
        test_read(1'b0, 13'h0005, 8'hA5, 2);
        test_write(1'b1, 13'h000A, 8'hC3, 1);
        test_read(1'b1, 13'h000A, 8'hC3, 1);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
